// File: rtl/bf16_bist_pkg.sv
// Shared types and constants for the bfloat16 FPU built-in self-test sequencer.
package bf16_bist_pkg;

  localparam int unsigned BF16_W = 16;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0100;
  localparam logic [OP_W-1:0] OP_DIV = 4'b1000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    DONE
  } state_e;

  // One golden vector: operands, expected result and expected overflow (49 bits).
  typedef struct packed {
    logic [BF16_W-1:0] in1;
    logic [BF16_W-1:0] in2;
    logic [BF16_W-1:0] gold;
    logic              ovf;
  } vec_t;

endpackage

// File: rtl/bf16_bist_vec_ram.sv
// Golden-vector storage: one synchronous write port, one combinational read port.
module bf16_bist_vec_ram
  import bf16_bist_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  vec_t          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output vec_t          rdata_c_o
);

  // Contents survive reset so a run can be repeated after an abort.
  vec_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/bf16_fpu_bist.sv
// BIST sequencer for the combinational bfloat16 FPU: replays stored vectors and checks results.
// Define BIST_OVF_CHECK_EN to also compare the FPU overflow flag against the stored bit.
module bf16_fpu_bist
  import bf16_bist_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we_i,
  input  logic [AW-1:0]     load_addr_i,
  input  logic [BF16_W-1:0] load_in1_i,
  input  logic [BF16_W-1:0] load_in2_i,
  input  logic [BF16_W-1:0] load_gold_i,
  input  logic              load_ovf_i,
  input  logic              start_i,
  input  logic [OP_W-1:0]   op_sel_i,
  input  logic [AW:0]       num_vec_i,
  output logic [OP_W-1:0]   fpu_op_o,
  output logic [BF16_W-1:0] fpu_in1_o,
  output logic [BF16_W-1:0] fpu_in2_o,
  input  logic [BF16_W-1:0] fpu_out_i,
  input  logic              fpu_ovf_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [AW:0]       err_cnt_o,
  output logic [AW-1:0]     first_err_idx_o,
  output logic [BF16_W-1:0] first_err_val_o
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = 4;

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       num_q, num_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic                run_ok_q, run_ok_d;
  logic [CW-1:0]       err_q, err_d;
  logic [AW-1:0]       fidx_q, fidx_d;
  logic [BF16_W-1:0]   fval_q, fval_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [OP_W-1:0]     fop_q, fop_d;
  logic [BF16_W-1:0]   in1_q, in1_d;
  logic [BF16_W-1:0]   in2_q, in2_d;

  vec_t rd_vec_c;
  vec_t wr_vec_c;
  logic ram_we_c;
  logic start_ok_c;
  logic last_c;
  logic mismatch_c;

  assign wr_vec_c = '{in1: load_in1_i, in2: load_in2_i, gold: load_gold_i, ovf: load_ovf_i};
  assign ram_we_c = load_we_i && (state_q == IDLE);

  bf16_bist_vec_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_vec_ram (
    .clk       (clk),
    .we_i      (ram_we_c),
    .waddr_i   (load_addr_i),
    .wdata_i   (wr_vec_c),
    .raddr_i   (idx_q),
    .rdata_c_o (rd_vec_c)
  );

  // A run needs a one-hot op and 1..DEPTH vectors.
  assign start_ok_c = (op_sel_i != '0)
                   && ((op_sel_i & (op_sel_i - OP_W'(1))) == '0)
                   && (num_vec_i != '0)
                   && (num_vec_i <= CW'(DEPTH));

  assign last_c = ({1'b0, idx_q} == (num_q - CW'(1)));

`ifdef BIST_OVF_CHECK_EN
  assign mismatch_c = (fpu_out_i != rd_vec_c.gold) || (fpu_ovf_i != rd_vec_c.ovf);
`else
  logic unused_ovf_c;
  assign mismatch_c   = (fpu_out_i != rd_vec_c.gold);
  assign unused_ovf_c = fpu_ovf_i ^ rd_vec_c.ovf;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    run_ok_d = run_ok_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fval_d   = fval_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    in1_d    = in1_q;
    in2_d    = in2_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d    = '0;
          fidx_d   = '1;
          fval_d   = '0;
          pass_d   = 1'b0;
          run_ok_d = start_ok_c;
          if (start_ok_c) begin
            idx_d   = '0;
            op_d    = op_sel_i;
            num_d   = num_vec_i;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        in1_d   = rd_vec_c.in1;
        in2_d   = rd_vec_c.in2;
        cnt_d   = SW'(SETTLE);
        state_d = (SETTLE == 0) ? CHECK : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - SW'(1);
        if (cnt_q <= SW'(1)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mismatch_c) begin
          if (err_q != CW'(DEPTH)) begin
            err_d = err_q + CW'(1);
          end
          if (err_q == '0) begin
            fidx_d = idx_q;
            fval_d = fpu_out_i;
          end
        end
        if (last_c) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ISSUE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = run_ok_q && (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ISSUE) || (state_d == WAIT) || (state_d == CHECK);
    fop_d  = busy_d ? op_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      num_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      run_ok_q <= 1'b0;
      err_q    <= '0;
      fidx_q   <= '1;
      fval_q   <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      fop_q    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      run_ok_q <= run_ok_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fval_q   <= fval_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      fop_q    <= fop_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
    end
  end

  assign fpu_op_o        = fop_q;
  assign fpu_in1_o       = in1_q;
  assign fpu_in2_o       = in2_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_cnt_o       = err_q;
  assign first_err_idx_o = fidx_q;
  assign first_err_val_o = fval_q;

endmodule

// File: tb/tb_bf16_fpu_bist.sv
// Self-checking bench for bf16_fpu_bist with a table-lookup FPU stand-in and a run scoreboard.
module tb_bf16_fpu_bist;
  import bf16_bist_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned SETTLE = 1;

  logic              clk;
  logic              rst;
  logic              load_we;
  logic [AW-1:0]     load_addr;
  logic [15:0]       load_in1, load_in2, load_gold;
  logic              load_ovf;
  logic              start;
  logic [3:0]        op_sel;
  logic [AW:0]       num_vec;
  logic [3:0]        fpu_op;
  logic [15:0]       fpu_in1, fpu_in2, fpu_out;
  logic              fpu_ovf;
  logic              busy, done, pass;
  logic [AW:0]       err_cnt;
  logic [AW-1:0]     first_idx;
  logic [15:0]       first_val;

  logic              ovr_en;
  logic [15:0]       ovr_a, ovr_b, ovr_val;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [3:0]  op;
    logic [AW:0] n;
    logic [AW:0] err;
    logic        pass;
    logic [3:0]  idx;
    logic [15:0] val;
    logic        chk_val;
    logic        valid;
    int          lat;
  } run_t;

  run_t sb_q[$];

  bf16_fpu_bist #(.DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_we_i       (load_we),
    .load_addr_i     (load_addr),
    .load_in1_i      (load_in1),
    .load_in2_i      (load_in2),
    .load_gold_i     (load_gold),
    .load_ovf_i      (load_ovf),
    .start_i         (start),
    .op_sel_i        (op_sel),
    .num_vec_i       (num_vec),
    .fpu_op_o        (fpu_op),
    .fpu_in1_o       (fpu_in1),
    .fpu_in2_o       (fpu_in2),
    .fpu_out_i       (fpu_out),
    .fpu_ovf_i       (fpu_ovf),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .err_cnt_o       (err_cnt),
    .first_err_idx_o (first_idx),
    .first_err_val_o (first_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known-good bf16 results for the operand pairs used here; anything else yields DEAD.
  function automatic logic [15:0] fpu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [35:0] key;
    key = {op, a, b};
    case (key)
      {OP_ADD, 16'h3F80, 16'h4000}: return 16'h4040;
      {OP_MUL, 16'h3F80, 16'h4000}: return 16'h4000;
      {OP_MUL, 16'h4000, 16'h4000}: return 16'h4080;
      {OP_MUL, 16'h4000, 16'h4040}: return 16'h40C0;
      {OP_MUL, 16'h4040, 16'h4040}: return 16'h4110;
      default:                      return 16'hDEAD;
    endcase
  endfunction

  always_comb begin
    fpu_out = fpu_ref(fpu_op, fpu_in1, fpu_in2);
    if (ovr_en && fpu_in1 == ovr_a && fpu_in2 == ovr_b) fpu_out = ovr_val;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic run_t mk_run(input logic [3:0] op, input int n, input int err,
                                  input logic ps, input logic [3:0] idx,
                                  input logic [15:0] val, input logic cv);
    run_t r;
    r.op      = op;
    r.n       = (AW+1)'(n);
    r.valid   = ($countones(op) == 1) && (n >= 1) && (n <= DEPTH);
    r.err     = (AW+1)'(err);
    r.pass    = ps;
    r.idx     = idx;
    r.val     = val;
    r.chk_val = cv;
    r.lat     = r.valid ? n * (SETTLE + 2) + 1 : 1;
    return r;
  endfunction

  task automatic load_vec(input int a, input logic [15:0] i1, input logic [15:0] i2,
                          input logic [15:0] g, input logic o);
    @(posedge clk); #1;
    load_we = 1'b1; load_addr = AW'(a);
    load_in1 = i1; load_in2 = i2; load_gold = g; load_ovf = o;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  task automatic load_mul_set();
    load_vec(0, 16'h3F80, 16'h4000, 16'h4000, 1'b0);
    load_vec(1, 16'h4000, 16'h4000, 16'h4080, 1'b0);
    load_vec(2, 16'h4000, 16'h4040, 16'h40C0, 1'b0);
    load_vec(3, 16'h4040, 16'h4040, 16'h4110, 1'b0);
  endtask

  // Push the expected outcome at start, pop and compare when done_o appears.
  task automatic run_and_check(input string nm, input run_t e);
    run_t x;
    int   cyc;
    logic busy_seen, op_seen, op_bad;
    sb_q.push_back(e);
    @(posedge clk); #1;
    op_sel = e.op; num_vec = e.n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; busy_seen = 1'b0; op_seen = 1'b0; op_bad = 1'b0;
    while (!done && cyc < 200) begin
      busy_seen = busy_seen | busy;
      op_seen   = op_seen | (fpu_op != 4'd0);
      op_bad    = op_bad | (fpu_op != 4'd0 && fpu_op != e.op);
      @(posedge clk); #1;
      cyc++;
    end
    x = sb_q.pop_front();
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " lat"}, 32'(cyc), 32'(x.lat));
    chk({nm, " err_cnt"}, 32'(err_cnt), 32'(x.err));
    chk({nm, " pass"}, 32'(pass), 32'(x.pass));
    chk({nm, " first_idx"}, 32'(first_idx), 32'(x.idx));
    if (x.chk_val) chk({nm, " first_val"}, 32'(first_val), 32'(x.val));
    chk({nm, " busy_seen"}, 32'(busy_seen), 32'(x.valid));
    chk({nm, " fpu_op"}, 32'({op_seen, op_bad}), x.valid ? 32'd2 : 32'd0);
    @(posedge clk); #1;
    chk({nm, " done 1cyc"}, 32'(done), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " done"}, 32'(done), 32'd0);
    chk({nm, " pass"}, 32'(pass), 32'd0);
    chk({nm, " err"}, 32'(err_cnt), 32'd0);
    chk({nm, " fidx"}, 32'(first_idx), 32'hF);
    chk({nm, " fval"}, 32'(first_val), 32'd0);
    chk({nm, " op"}, 32'(fpu_op), 32'd0);
    chk({nm, " in"}, {fpu_in1, fpu_in2}, 32'd0);
  endtask

  run_t inv_tab[4];
  logic done_seen;

  initial begin
    inv_tab[0] = mk_run(4'b0110, 1, 0, 1'b0, 4'hF, 16'h0, 1'b0);
    inv_tab[1] = mk_run(OP_ADD,  0, 0, 1'b0, 4'hF, 16'h0, 1'b0);
    inv_tab[2] = mk_run(4'b0000, 2, 0, 1'b0, 4'hF, 16'h0, 1'b0);
    inv_tab[3] = mk_run(4'b1100, 3, 0, 1'b0, 4'hF, 16'h0, 1'b0);

    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_in1 = '0; load_in2 = '0;
    load_gold = '0; load_ovf = 1'b0; start = 1'b0; op_sel = '0; num_vec = '0;
    fpu_ovf = 1'b0; ovr_en = 1'b0; ovr_a = '0; ovr_b = '0; ovr_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Single add vector, correct FPU.
    load_vec(0, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
    run_and_check("add1", mk_run(OP_ADD, 1, 0, 1'b1, 4'hF, 16'h0, 1'b1));

    // Four mul vectors, FPU wrong on index 2.
    load_mul_set();
    ovr_en = 1'b1; ovr_a = 16'h4000; ovr_b = 16'h4040; ovr_val = 16'h40A0;
    run_and_check("mul4", mk_run(OP_MUL, 4, 1, 1'b0, 4'h2, 16'h40A0, 1'b1));
    ovr_en = 1'b0;

    for (int i = 0; i < 4; i++) run_and_check($sformatf("inv%0d", i), inv_tab[i]);

    // Every vector mismatches: counter saturates at DEPTH, then N=DEPTH+1 is rejected.
    for (int i = 0; i < DEPTH; i++)
      load_vec(i, 16'h0100 + 16'(i), 16'h0000, 16'h1000 + 16'(i), 1'b0);
    run_and_check("sat16", mk_run(OP_ADD, 16, 16, 1'b0, 4'h0, 16'hDEAD, 1'b1));
    run_and_check("n17", mk_run(OP_ADD, 17, 0, 1'b0, 4'hF, 16'h0, 1'b0));

    // Reset during WAIT of vector 3, then rerun from the same RAM.
    load_mul_set();
    @(posedge clk); #1;
    op_sel = OP_MUL; num_vec = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrun busy", 32'(busy), 32'd1);
    chk("midrun vec3", {fpu_in1, fpu_in2}, 32'h40404040);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      done_seen = done_seen | done | busy;
    end
    chk("midrst quiet", 32'(done_seen), 32'd0);
    run_and_check("rerun", mk_run(OP_MUL, 4, 0, 1'b1, 4'hF, 16'h0, 1'b1));

    // Stored overflow set while the FPU reports none.
    load_vec(0, 16'h3F80, 16'h4000, 16'h4040, 1'b1);
`ifdef BIST_OVF_CHECK_EN
    run_and_check("ovf", mk_run(OP_ADD, 1, 1, 1'b0, 4'h0, 16'h4040, 1'b1));
`else
    run_and_check("ovf", mk_run(OP_ADD, 1, 0, 1'b1, 4'hF, 16'h0, 1'b1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
